// File: rtl/round_key_reader.sv
// round_key_reader: stores serially loaded round keys and replays them in forward or reverse order
module round_key_reader #(
    parameter int KEY_W    = 128,
    parameter int NUM_KEYS = 11,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             key_in_valid,
    input  logic [KEY_W-1:0] key_in,
    output logic             key_in_ready,
    output logic             load_done,
    input  logic             req_valid,
    input  logic             req_dir,
    output logic             req_ready,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_data,
    output logic [IDX_W-1:0] rk_index,
    output logic             rk_last,
    output logic             busy
);
    typedef enum logic [1:0] {LOAD, IDLE, SERVE} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_KEYS - 1);
    state_t           state;
    logic [KEY_W-1:0] mem [NUM_KEYS];
    logic [IDX_W-1:0] wr_ptr, rd_ptr, nxt_ptr, start_ptr;
    logic             dir;
    assign key_in_ready = state == LOAD;
    assign req_ready    = state == IDLE;
    assign busy         = state == SERVE;
    assign rk_index     = rd_ptr;
    assign nxt_ptr      = dir ? rd_ptr - 1'b1 : rd_ptr + 1'b1;
    assign start_ptr    = req_dir ? LAST : '0;
    // key storage survives reset and clear; written only by accepted load beats
    always_ff @(posedge clk)
        if (!rst && !clear && key_in_ready && key_in_valid) mem[wr_ptr] <= key_in;
    // load/idle/serve control with registered beat outputs so data stays stable under stall
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= LOAD;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dir       <= 1'b0;
            load_done <= 1'b0;
            rk_valid  <= 1'b0;
            rk_data   <= '0;
            rk_last   <= 1'b0;
        end else begin
            case (state)
                LOAD: if (key_in_valid) begin
                    wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
                    if (wr_ptr == LAST) begin
                        state     <= IDLE;
                        load_done <= 1'b1;
                    end
                end
                IDLE: if (req_valid) begin
                    state    <= SERVE;
                    dir      <= req_dir;
                    rd_ptr   <= start_ptr;
                    rk_data  <= mem[start_ptr];
                    rk_valid <= 1'b1;
                    rk_last  <= NUM_KEYS == 1;
                end
                SERVE: if (rk_ready) begin
                    if (rk_last) begin
                        state    <= IDLE;
                        rk_valid <= 1'b0;
                        rk_last  <= 1'b0;
                    end else begin
                        rd_ptr  <= nxt_ptr;
                        rk_data <= mem[nxt_ptr];
                        rk_last <= nxt_ptr == (dir ? IDX_W'(0) : LAST);
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_round_key_reader.sv
// tb_round_key_reader: randomized load/serve stimulus checked against an array-and-order model
module tb_round_key_reader;
    logic         clk = 0, rst = 1, clear = 0;
    logic         key_in_valid = 0, req_valid = 0, req_dir = 0, rk_ready = 0;
    logic [127:0] key_in = '0;
    logic         key_in_ready, load_done, req_ready, rk_valid, rk_last, busy;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic [127:0] ref_mem [11];
    int           checks = 0, errors = 0;

    round_key_reader dut (
        .clk(clk), .rst(rst), .clear(clear),
        .key_in_valid(key_in_valid), .key_in(key_in), .key_in_ready(key_in_ready),
        .load_done(load_done), .req_valid(req_valid), .req_dir(req_dir), .req_ready(req_ready),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_index(rk_index),
        .rk_last(rk_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_kready"}, 128'(key_in_ready), 128'd1);
        check({tag, "_rready"}, 128'(req_ready), 128'd0);
        check({tag, "_done"}, 128'(load_done), 128'd0);
        check({tag, "_valid"}, 128'(rk_valid), 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_last"}, 128'(rk_last), 128'd0);
    endtask

    // drive load beats until nbeats are accepted; fixed selects the A5A5 pattern keys
    task automatic load_keys(input int nbeats, input bit gaps, input bit fixed);
        int n = 0, cyc = 0;
        logic [127:0] k;
        while (n < nbeats && cyc < 400) begin
            @(negedge clk);
            check("load_kready", 128'(key_in_ready), 128'd1);
            check("load_done_low", 128'(load_done), 128'd0);
            check("load_rready", 128'(req_ready), 128'd0);
            check("load_rk_valid", 128'(rk_valid), 128'd0);
            key_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            req_valid    = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            k = fixed ? ({16'hA5A5, 112'd0} | 128'(n)) : {$urandom(), $urandom(), $urandom(), $urandom()};
            key_in = k;
            if (key_in_valid) begin
                ref_mem[n] = k;
                n++;
            end
            cyc++;
        end
        if (n < nbeats) check("load_timeout", 128'(n), 128'(nbeats));
        @(negedge clk);
        key_in_valid = 0;
        req_valid = 0;
        if (nbeats == 11) begin
            check("load_done_high", 128'(load_done), 128'd1);
            check("idle_kready", 128'(key_in_ready), 128'd0);
            check("idle_rready", 128'(req_ready), 128'd1);
        end
    endtask

    // request a sequence; mode 0 ready high, 1 toggling, 2 random; stop < 11 abandons early
    task automatic serve(input bit dir, input int mode, input int stop);
        int k = 0, cyc = 0, e;
        bit t = 1;
        @(negedge clk);
        check("req_ready_pre", 128'(req_ready), 128'd1);
        req_valid = 1;
        req_dir = dir;
        rk_ready = 0;
        while (k < 11 && k < stop && cyc < 200) begin
            @(negedge clk);
            req_valid = 0;
            e = dir ? 10 - k : k;
            check("beat_valid", 128'(rk_valid), 128'd1);
            check("beat_busy", 128'(busy), 128'd1);
            check("beat_rready", 128'(req_ready), 128'd0);
            check("beat_index", 128'(rk_index), 128'(e));
            check("beat_data", rk_data, ref_mem[e]);
            check("beat_last", 128'(rk_last), 128'(k == 10));
            rk_ready = mode == 0 ? 1'b1 : mode == 1 ? t : 1'($urandom_range(0, 1));
            t = ~t;
            if (rk_ready) k++;
            cyc++;
        end
        if (stop >= 11) begin
            if (mode == 0) check("beat_cycles", 128'(cyc), 128'd11);
            @(negedge clk);
            rk_ready = 0;
            check("post_valid", 128'(rk_valid), 128'd0);
            check("post_rready", 128'(req_ready), 128'd1);
            check("post_busy", 128'(busy), 128'd0);
            check("post_done", 128'(load_done), 128'd1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        check_reset_outputs("reset");
        check("reset_data", rk_data, 128'd0);
        check("reset_index", 128'(rk_index), 128'd0);
        // 1: fixed keys, back-to-back
        load_keys(11, 0, 1);
        // key_in ignored outside LOAD
        @(negedge clk);
        key_in_valid = 1;
        key_in = '1;
        @(negedge clk);
        key_in_valid = 0;
        check("idle_ignore_kready", 128'(key_in_ready), 128'd0);
        // 2 and 3
        serve(0, 0, 11);
        serve(1, 1, 11);
        // 4: gapped load with stray requests, then random backpressure
        @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        check_reset_outputs("clear_a");
        load_keys(11, 1, 0);
        serve(0, 2, 11);
        serve(1, 2, 11);
        // 5: clear mid-sequence after 4 beats
        serve(0, 0, 4);
        @(negedge clk);
        check("pre_clear_valid", 128'(rk_valid), 128'd1);
        check("pre_clear_index", 128'(rk_index), 128'd4);
        rk_ready = 0;
        clear = 1;
        @(negedge clk);
        clear = 0;
        check_reset_outputs("clear_b");
        load_keys(11, 0, 0);
        serve(0, 0, 11);
        // 6: reset after 5 load beats
        @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        load_keys(5, 0, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_reset_outputs("rst_mid");
        check("rst_mid_data", rk_data, 128'd0);
        load_keys(11, 1, 1);
        serve(1, 2, 11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
